// File: rtl/unidad_control_if.sv
// Sequencer <-> ROM/datapath bus: instruction fetch, flags in, control word out.
interface unidad_control_if #(
   parameter int PC_W = 4
);
   logic [11:0]     instr;
   logic [3:0]      flags;
   logic [PC_W-1:0] instr_addr;
   logic [15:0]     control;
   logic [3:0]      Constant_IN;
   logic            out_strobe;

   modport master (
      input  instr, flags,
      output instr_addr, control, Constant_IN, out_strobe
   );

   modport slave (
      output instr, flags,
      input  instr_addr, control, Constant_IN, out_strobe
   );
endinterface

// File: rtl/unidad_control.sv
// Multicycle hardwired sequencer for unidad_procesadora: FETCH then EXEC per instruction.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, waiting for start; control word held at 0
// S_FETCH | ir <= ROM[pc], pc <= pc+1; control word 0
// S_EXEC  | control/constant decoded from ir; flags latched; jumps resolved
// S_HALT  | stopped after HALT opcode; start restarts from pc=0
module unidad_control #(
   parameter int         PC_W       = 4,
   parameter logic [3:0] ALU_ADD    = 4'b0000,
   parameter logic [3:0] ALU_SUB    = 4'b0001,
   parameter logic [3:0] ALU_AND    = 4'b0010,
   parameter logic [3:0] ALU_OR     = 4'b0011,
   parameter logic [3:0] ALU_PASS_A = 4'b0100,
   parameter logic [3:0] ALU_PASS_B = 4'b0101,
   parameter logic [1:0] SH_NONE    = 2'b00,
   parameter logic [1:0] SH_LEFT    = 2'b01,
   parameter logic [1:0] SH_RIGHT   = 2'b10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic busy,
   output logic halted,
   unidad_control_if.master bus
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

   state_t          state_q;
   logic [PC_W-1:0] pc_q;
   logic [11:0]     ir_q;
   logic            zf_q, cf_q;
   logic            busy_q, halted_q;

   logic [3:0] op;
   logic [1:0] rd, ra, rb;
   logic [3:0] imm;

   assign op  = ir_q[11:8];
   assign rd  = ir_q[7:6];
   assign ra  = ir_q[5:4];
   assign rb  = ir_q[3:2];
   assign imm = ir_q[3:0];

   logic [1:0] reg_a, reg_b, dest, sel_sh;
   logic       we, mb, mf, md, strobe;
   logic [3:0] sel_alu;
   logic       alu_op, take_jump;

   // Instruction decode; only meaningful while in EXEC.
   always_comb begin
      reg_a   = ra;
      reg_b   = rb;
      dest    = rd;
      we      = 1'b0;
      mb      = 1'b0;
      sel_alu = ALU_ADD;
      sel_sh  = SH_NONE;
      mf      = 1'b0;
      md      = 1'b0;
      strobe  = 1'b0;
      case (op)
         4'h0, 4'hE: begin
            reg_a = 2'b00;
            reg_b = 2'b00;
            dest  = 2'b00;
         end
         4'h1: begin we = 1'b1; sel_alu = ALU_ADD; end
         4'h2: begin we = 1'b1; sel_alu = ALU_SUB; end
         4'h3: begin we = 1'b1; sel_alu = ALU_AND; end
         4'h4: begin we = 1'b1; sel_alu = ALU_OR;  end
         4'h5: begin we = 1'b1; mb = 1'b1; sel_alu = ALU_ADD;    end
         4'h6: begin we = 1'b1; mb = 1'b1; sel_alu = ALU_PASS_B; end
         4'h7: begin we = 1'b1; md = 1'b1; end
         4'h8: begin
            reg_b   = ra;
            sel_alu = ALU_PASS_A;
            strobe  = 1'b1;
         end
         4'h9, 4'hA: begin
            we      = 1'b1;
            reg_b   = ra;
            sel_alu = ALU_PASS_B;
            mf      = 1'b1;
            sel_sh  = (op == 4'h9) ? SH_LEFT : SH_RIGHT;
         end
         default: ;
      endcase
   end

   // Branches test the flags latched by the last ALU op, never the live ones.
   always_comb begin
      alu_op    = (op >= 4'h1 && op <= 4'h5) || op == 4'h9 || op == 4'hA;
      take_jump = (op == 4'hB) || (op == 4'hC && zf_q) || (op == 4'hD && cf_q);
   end

   // Control word is gated by state so an async reset drops it (and we) at once.
   always_comb begin
      bus.instr_addr  = pc_q;
      bus.control     = '0;
      bus.Constant_IN = '0;
      bus.out_strobe  = 1'b0;
      if (state_q == S_EXEC) begin
         bus.control     = {reg_a, reg_b, dest, we, mb, sel_alu, sel_sh, mf, md};
         bus.Constant_IN = imm;
         bus.out_strobe  = strobe;
      end
   end

   assign busy   = busy_q;
   assign halted = halted_q;

   // Sequencer state, program counter, instruction and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         ir_q     <= '0;
         zf_q     <= 1'b0;
         cf_q     <= 1'b0;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_HALT: begin
               if (start) begin
                  state_q  <= S_FETCH;
                  pc_q     <= '0;
                  zf_q     <= 1'b0;
                  cf_q     <= 1'b0;
                  busy_q   <= 1'b1;
                  halted_q <= 1'b0;
               end
            end
            S_FETCH: begin
               ir_q    <= bus.instr;
               pc_q    <= pc_q + PC_W'(1);
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               if (alu_op) begin
                  zf_q <= bus.flags[0];
                  cf_q <= bus.flags[1];
               end
               if (take_jump) pc_q <= PC_W'(imm);
               if (op == 4'hF) begin
                  state_q  <= S_HALT;
                  busy_q   <= 1'b0;
                  halted_q <= 1'b1;
               end else begin
                  state_q <= S_FETCH;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_unidad_control.sv
// Bench for unidad_control: ISA-level model feeds a scoreboard of per-cycle bus records.
module tb_unidad_control;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic busy, halted;

   unidad_control_if #(.PC_W(4)) bus ();

   unidad_control dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .busy   (busy),
      .halted (halted),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   logic [11:0] rom      [16];
   logic [3:0]  flag_tab [16];
   logic [3:0]  flags_drv = 4'h0;
   logic [15:0] obs_ctl  [64];
   logic [3:0]  obs_addr [64];

   assign bus.instr = rom[bus.instr_addr];
   assign bus.flags = flags_drv;

   // {addr, control, Constant_IN, out_strobe, busy, halted}
   typedef logic [26:0] rec_t;
   rec_t sb_q[$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic rec_t pack(input int addr, input logic [15:0] ctl, input logic [3:0] k,
                                 input logic strb, input logic bsy, input logic hlt);
      return {4'(addr), ctl, k, strb, bsy, hlt};
   endfunction

   function automatic rec_t cur_obs();
      return {bus.instr_addr, bus.control, bus.Constant_IN, bus.out_strobe, busy, halted};
   endfunction

   task automatic score(input string tag);
      if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      else chk(tag, 32'(cur_obs()), 32'(sb_q.pop_front()));
   endtask

   task automatic expect_cycle(input string tag);
      @(negedge clk);
      score(tag);
   endtask

   // Reference decode: {out_strobe, control, Constant_IN}.
   function automatic logic [20:0] model_exec(input logic [11:0] ins);
      logic [3:0] op, imm, alu;
      logic [1:0] a, b, d, sh;
      logic we, mb, mf, md, so;
      op = ins[11:8]; d = ins[7:6]; a = ins[5:4]; b = ins[3:2]; imm = ins[3:0];
      we = 0; mb = 0; mf = 0; md = 0; so = 0; alu = 4'h0; sh = 2'b00;
      if (op == 4'h0 || op == 4'hE) begin a = 0; b = 0; d = 0; end
      else if (op >= 4'h1 && op <= 4'h4) begin we = 1; alu = op - 4'h1; end
      else if (op == 4'h5) begin we = 1; mb = 1; end
      else if (op == 4'h6) begin we = 1; mb = 1; alu = 4'h5; end
      else if (op == 4'h7) begin we = 1; md = 1; end
      else if (op == 4'h8) begin b = a; alu = 4'h4; so = 1; end
      else if (op == 4'h9 || op == 4'hA) begin
         we = 1; b = a; alu = 4'h5; mf = 1; sh = (op == 4'h9) ? 2'b01 : 2'b10;
      end
      return {so, a, b, d, we, mb, alu, sh, mf, md, imm};
   endfunction

   // Runs from IDLE/HALT; returns at posedge+1 in HALT (halt_seen) or in FETCH.
   task automatic run_prog(input int max_instr, input bit busy_start, output bit halt_seen);
      int pc, nxt;
      bit zf, cf;
      logic [11:0] ins;
      logic [3:0]  op;
      logic [20:0] e;
      pc = 0; zf = 0; cf = 0; halt_seen = 0;
      start = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < max_instr; i++) begin
         start = (busy_start && i >= 1 && i <= 2);
         flags_drv = 4'($urandom);
         ins = rom[pc];
         sb_q.push_back(pack(pc, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0));
         expect_cycle("fetch");
         obs_addr[i] = bus.instr_addr;
         @(posedge clk); #1;
         flags_drv = flag_tab[pc];
         e = model_exec(ins);
         sb_q.push_back(pack((pc + 1) % 16, e[19:4], e[3:0], e[20], 1'b1, 1'b0));
         expect_cycle("exec");
         obs_ctl[i] = bus.control;
         op = ins[11:8];
         if ((op >= 4'h1 && op <= 4'h5) || op == 4'h9 || op == 4'hA) begin
            zf = flag_tab[pc][0];
            cf = flag_tab[pc][1];
         end
         nxt = (pc + 1) % 16;
         if (op == 4'hB || (op == 4'hC && zf) || (op == 4'hD && cf)) nxt = int'(ins[3:0]);
         pc = nxt;
         @(posedge clk); #1;
         if (op == 4'hF) begin
            start = 1'b0;
            sb_q.push_back(pack(pc, 16'h0, 4'h0, 1'b0, 1'b0, 1'b1));
            expect_cycle("halt");
            @(posedge clk); #1;
            halt_seen = 1;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic clear_rom();
      for (int a = 0; a < 16; a++) begin
         rom[a] = 12'h000;
         flag_tab[a] = 4'h0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   bit hs;

   initial begin
      clear_rom();
      // Reset state
      #12 rst_n = 1'b1;
      @(posedge clk); #1;
      sb_q.push_back(pack(0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0));
      expect_cycle("reset_idle");
      @(posedge clk); #1;

      // LDI r1,#5 ; OUT r1 ; HALT
      rom[0] = 12'h645; rom[1] = 12'h810; rom[2] = 12'hF00;
      run_prog(10, 0, hs);
      chk("ldi_ctl", 32'(obs_ctl[0]), 32'h1750);
      chk("out_ctl", 32'(obs_ctl[1]), 32'h5040);
      chk("ldi_halt", 32'(hs), 32'd1);

      // LDI r0,#0 ; SUB with Z=1 ; JZ 7 -> taken
      clear_rom();
      rom[0] = 12'h600; rom[1] = 12'h200; rom[2] = 12'hC07; rom[3] = 12'hF00; rom[7] = 12'hF00;
      flag_tab[1] = 4'b0001;
      run_prog(10, 0, hs);
      chk("jz_taken_addr", 32'(obs_addr[3]), 32'd7);

      // Same with Z=0 -> fall through
      flag_tab[1] = 4'b0000;
      flag_tab[2] = 4'b0001;
      run_prog(10, 0, hs);
      chk("jz_fall_addr", 32'(obs_addr[3]), 32'd3);

      // NOP between SUB and JZ: latched zf still jumps though live Z=0
      clear_rom();
      rom[0] = 12'h600; rom[1] = 12'h200; rom[2] = 12'h000; rom[3] = 12'hC09;
      rom[4] = 12'hF00; rom[9] = 12'hF00;
      flag_tab[1] = 4'b0001;
      run_prog(10, 0, hs);
      chk("jz_latched_addr", 32'(obs_addr[4]), 32'd9);

      // Wrap: JC (not taken), JMP 15, ADD at 15 sets C, wraps to 0, JC taken
      clear_rom();
      rom[0] = 12'hD03; rom[1] = 12'hB0F; rom[15] = 12'h100; rom[2] = 12'hF00; rom[3] = 12'hF00;
      flag_tab[15] = 4'b0010;
      run_prog(10, 0, hs);
      chk("wrap_addr", 32'(obs_addr[3]), 32'd0);
      chk("wrap_jc_addr", 32'(obs_addr[4]), 32'd3);

      // HALT then start clears zf: JZ must fall through
      clear_rom();
      rom[0] = 12'h200; rom[1] = 12'hF00; flag_tab[0] = 4'b0011;
      run_prog(10, 0, hs);
      clear_rom();
      rom[0] = 12'hC05; rom[1] = 12'hF00; rom[5] = 12'hF00;
      run_prog(10, 0, hs);
      chk("restart_zf_clr", 32'(obs_addr[1]), 32'd1);

      // start held during busy has no effect
      clear_rom();
      rom[4] = 12'hF00;
      run_prog(10, 1, hs);
      chk("busy_start_halt", 32'(hs), 32'd1);

      // Tight loop JMP 15 at 15
      clear_rom();
      rom[0] = 12'hB0F; rom[15] = 12'hB0F;
      run_prog(6, 0, hs);
      @(negedge clk);
      chk("loop_busy", 32'(busy), 32'd1);
      chk("loop_addr", 32'(bus.instr_addr), 32'd15);
      do_reset();

      // Reset during EXEC of ADD r1,r2,r3
      clear_rom();
      rom[0] = 12'h16C;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      chk("add_we", 32'(bus.control[9]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      sb_q.push_back(pack(0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0));
      score("rst_async");
      @(posedge clk); #3 rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         sb_q.push_back(pack(0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0));
         expect_cycle("rst_idle");
      end
      @(posedge clk); #1;

      // Random programs
      for (int r = 0; r < 4; r++) begin
         for (int a = 0; a < 16; a++) begin
            rom[a] = 12'($urandom);
            flag_tab[a] = 4'($urandom);
         end
         rom[$urandom_range(2, 15)] = 12'hF00;
         run_prog(30, 0, hs);
         if (!hs) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
